yankee_operand_sequencer: RTL and testbench
===========================================

// Module: yankee_operand_sequencer
// PURPOSE
//  Upstream feeder for the quadratic solver (y = a*x^2 + b*x + c).
//  - Accepts operand tuples {x,a,b,c} from a host over a valid/ready handshake.
//  - Buffers them in a small FIFO.
//  - Issues them one at a time using the solver's enable/valid/ready protocol.
//  - Returns each result y with a sequence tag, and flags solver timeouts.
// PARAMETERS
//  DEPTH    4    FIFO depth in tuples (power of two, >=2)
//  SEQ_W    8    width of result sequence tag
//  TIMEOUT  255  max cycles from sol_enable to solver valid before abort (>=2)
// PORTS
//  clock       in   1        single clock, rising edge
//  reset       in   1        asynchronous, active-low; 0 = in reset
//  in_valid    in   1        host tuple present
//  in_ready    out  1        FIFO can accept (= !full)
//  in_x        in   8        signed x
//  in_a        in   16       signed a
//  in_b        in   16       signed b
//  in_c        in   16       signed c
//  sol_x       out  8        registered x to solver
//  sol_a       out  16       registered a to solver
//  sol_b       out  16       registered b to solver
//  sol_c       out  16       registered c to solver
//  sol_enable  out  1        one-cycle start pulse to solver
//  sol_valid   in   1        solver result valid
//  sol_ready   in   1        solver idle/ready
//  sol_y       in   16       signed solver result
//  res_valid   out  1        one-cycle pulse: res_y/res_seq valid
//  res_y       out  16       captured signed result
//  res_seq     out  SEQ_W    tag of tuple that produced res_y
//  pending     out  clog2(DEPTH+1)  tuples queued in FIFO
//  err         out  1        sticky timeout flag
// BEHAVIOUR
//  Reset (async, reset=0):
//   - FIFO empty; state IDLE; pending=0; in_ready=1.
//   - All sol_* outputs, res_y, res_seq, res_valid, sol_enable and err = 0.
//   - Reset at any point in operation discards queued and in-flight tuples.
//  FIFO:
//   - Push when in_valid && in_ready. Pop only on issue.
//   - Push and pop in the same cycle are both honoured; pending is unchanged.
//   - When full, in_ready=0 in that cycle even if a pop occurs; there is no bypass.
//   - A tuple pushed into an empty FIFO is first visible on the next edge.
//   - Read/write pointers wrap modulo DEPTH.
//  FSM IDLE -> WAIT_VALID -> WAIT_READY -> IDLE:
//   - IDLE: if pending>0 && sol_ready, then at this edge:
//     - pop the head and register it into sol_x/a/b/c;
//     - set sol_enable=1 and go to WAIT_VALID.
//     - sol_enable drops on the following edge, so the pulse is exactly one cycle.
//     - Minimum latency: push at edge k -> sol_enable high after edge k+1.
//   - sol_x/a/b/c are held stable from issue until the next issue.
//   - WAIT_VALID: capture only on a rising edge of sol_valid (registered prev=0, now=1).
//     - A stale high sol_valid carried over from before issue is ignored.
//     - On capture: res_y <= sol_y, res_seq <= tag of the issued tuple, res_valid=1
//       for one cycle; go to WAIT_READY.
//   - Timeout counter starts at 0 on issue.
//     - If it reaches TIMEOUT-1 with no capture: err <= 1 (sticky until reset).
//     - The tuple is dropped with no res_valid pulse; go to IDLE.
//   - WAIT_READY: wait for sol_ready=1, then go to IDLE.
//     - Back-to-back issue is possible on the next IDLE cycle.
//  Tag: increments by one per issued tuple, wraps 2^SEQ_W-1 -> 0.
//   - Timed-out tuples still consume a tag.
//  Arithmetic: none; all data passes through unmodified (two's complement preserved).
// STRUCTURE
//  Package yankee_pkg:
//   - X_W=8, COEF_W=16, Y_W=16;
//   - operand tuple struct/width constant;
//   - FSM state encodings.
//  One sub-module: yankee_operand_fifo (parameterised DEPTH, data width 56).
//   - Synchronous push/pop, full/empty/count.
//  FSM, timeout counter, valid edge detect and result registers live in the top.
// TESTING
//  - Assert reset=0 mid WAIT_VALID with 3 queued -> next cycle pending=0,
//    sol_enable=0, res_valid=0, err=0, in_ready=1.
//  - Push x=3,a=2,b=-1,c=5 into the idle design; solver model gives y=20
//    5 cycles after enable. Required:
//    - sol_enable high exactly 1 cycle, 1 cycle after push;
//    - res_valid 1 cycle with res_y=20, res_seq=0.
//  - Hold sol_ready=0 and push 5 tuples back-to-back -> 4 accepted, pending=4,
//    in_ready=0. Release sol_ready -> issue order equals push order, 5th accepted
//    after first pop.
//  - Tuples (x=-2,a=1,b=0,c=0), (x=-128,a=1,b=0,c=0), (x=1,a=-1,b=-1,c=-1) ->
//    res_y=4, 16384, -3 with res_seq=0,1,2.
//  - TIMEOUT=16, solver never raises sol_valid -> err=1 at cycle 16 after
//    enable; FSM returns to IDLE; the next tuple issues and completes normally.
//  - sol_valid held high across an issue -> no capture until it falls and
//    rises again. With SEQ_W=2, 5 tuples -> res_seq 0,1,2,3,0.

Source files
------------

// File: rtl/yankee_pkg.sv
// Shared widths, operand tuple layout and FSM encodings for the operand sequencer.
package yankee_pkg;

  localparam int X_W    = 8;
  localparam int COEF_W = 16;
  localparam int Y_W    = 16;

  // Packed tuple, x in the top bits so {x,a,b,c} concatenation matches field order.
  localparam int OPER_W = X_W + 3 * COEF_W;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [COEF_W-1:0] a;
    logic [COEF_W-1:0] b;
    logic [COEF_W-1:0] c;
  } operand_t;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_VALID = 2'd1;
  localparam logic [1:0] ST_WAIT_READY = 2'd2;

endpackage

// File: rtl/yankee_operand_fifo.sv
// Small tuple FIFO: head is read combinationally so the sequencer can pop and
// register the head in the same edge; push and pop may coincide.
module yankee_operand_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 56
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              push_ok;
  logic              pop_ok;

  // Full blocks pushes even when a pop happens in the same cycle (no bypass).
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

  // Storage array, no reset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/yankee_operand_sequencer.sv
// Feeds buffered {x,a,b,c} tuples to the quadratic solver one at a time,
// returns tagged results and flags solver timeouts.
module yankee_operand_sequencer
  import yankee_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SEQ_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [X_W-1:0]             in_x,
  input  logic [COEF_W-1:0]          in_a,
  input  logic [COEF_W-1:0]          in_b,
  input  logic [COEF_W-1:0]          in_c,
  output logic [X_W-1:0]             sol_x,
  output logic [COEF_W-1:0]          sol_a,
  output logic [COEF_W-1:0]          sol_b,
  output logic [COEF_W-1:0]          sol_c,
  output logic                       sol_enable,
  input  logic                       sol_valid,
  input  logic                       sol_ready,
  input  logic [Y_W-1:0]             sol_y,
  output logic                       res_valid,
  output logic [Y_W-1:0]             res_y,
  output logic [SEQ_W-1:0]           res_seq,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       err
);

  localparam int TMO_W = $clog2(TIMEOUT);

  operand_t          in_tuple;
  operand_t          head_tuple;
  logic [OPER_W-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue;

  logic [1:0]        state_reg;
  logic [X_W-1:0]    sol_x_reg;
  logic [COEF_W-1:0] sol_a_reg;
  logic [COEF_W-1:0] sol_b_reg;
  logic [COEF_W-1:0] sol_c_reg;
  logic              sol_enable_reg;
  logic              valid_prev_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [SEQ_W-1:0]  seq_reg;
  logic [SEQ_W-1:0]  cur_tag_reg;
  logic              res_valid_reg;
  logic [Y_W-1:0]    res_y_reg;
  logic [SEQ_W-1:0]  res_seq_reg;
  logic              err_reg;

  assign in_tuple   = {in_x, in_a, in_b, in_c};
  assign head_tuple = head_data;
  assign in_ready   = !fifo_full;
  assign issue      = (state_reg == ST_IDLE) && !fifo_empty && sol_ready;

  yankee_operand_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (OPER_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_tuple),
    .pop       (issue),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  // Issue FSM with timeout, sol_valid rising-edge capture and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      sol_x_reg      <= '0;
      sol_a_reg      <= '0;
      sol_b_reg      <= '0;
      sol_c_reg      <= '0;
      sol_enable_reg <= 1'b0;
      valid_prev_reg <= 1'b0;
      tmo_cnt_reg    <= '0;
      seq_reg        <= '0;
      cur_tag_reg    <= '0;
      res_valid_reg  <= 1'b0;
      res_y_reg      <= '0;
      res_seq_reg    <= '0;
      err_reg        <= 1'b0;
    end else begin
      valid_prev_reg <= sol_valid;
      sol_enable_reg <= 1'b0;
      res_valid_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (issue) begin
            sol_x_reg      <= head_tuple.x;
            sol_a_reg      <= head_tuple.a;
            sol_b_reg      <= head_tuple.b;
            sol_c_reg      <= head_tuple.c;
            sol_enable_reg <= 1'b1;
            cur_tag_reg    <= seq_reg;
            seq_reg        <= seq_reg + 1'b1;
            tmo_cnt_reg    <= '0;
            state_reg      <= ST_WAIT_VALID;
          end
        end
        ST_WAIT_VALID: begin
          // A level left high from before the issue never forms a rising edge.
          if (sol_valid && !valid_prev_reg) begin
            res_y_reg     <= sol_y;
            res_seq_reg   <= cur_tag_reg;
            res_valid_reg <= 1'b1;
            state_reg     <= ST_WAIT_READY;
          end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_READY: begin
          if (sol_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sol_x      = sol_x_reg;
  assign sol_a      = sol_a_reg;
  assign sol_b      = sol_b_reg;
  assign sol_c      = sol_c_reg;
  assign sol_enable = sol_enable_reg;
  assign res_valid  = res_valid_reg;
  assign res_y      = res_y_reg;
  assign res_seq    = res_seq_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_yankee_operand_sequencer.sv
// Directed bench for the operand sequencer with a small behavioural solver.
module tb_yankee_operand_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [15:0] in_c = '0;
  logic [7:0]  sol_x;
  logic [15:0] sol_a;
  logic [15:0] sol_b;
  logic [15:0] sol_c;
  logic        sol_enable;
  logic        sol_valid;
  logic        sol_ready;
  logic [15:0] sol_y;
  logic        res_valid;
  logic [15:0] res_y;
  logic [1:0]  res_seq;
  logic [2:0]  pending;
  logic        err;

  // solver model controls: mode 0 normal, 1 never valid, 2 valid held high while idle
  int  mode = 0;
  bit  hold_ready = 1'b0;
  bit  busy;
  int  cnt;
  int  model_y;

  int  n_tests = 0;
  int  n_fail  = 0;

  int  iss_x_q[$];
  int  res_y_q[$];
  int  res_seq_q[$];

  yankee_operand_sequencer #(
    .DEPTH   (4),
    .SEQ_W   (2),
    .TIMEOUT (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c       (in_c),
    .sol_x      (sol_x),
    .sol_a      (sol_a),
    .sol_b      (sol_b),
    .sol_c      (sol_c),
    .sol_enable (sol_enable),
    .sol_valid  (sol_valid),
    .sol_ready  (sol_ready),
    .sol_y      (sol_y),
    .res_valid  (res_valid),
    .res_y      (res_y),
    .res_seq    (res_seq),
    .pending    (pending),
    .err        (err)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Solver: result valid 5 cycles after the enable pulse, busy (not ready) meanwhile.
  initial begin
    sol_valid = 1'b0;
    sol_ready = 1'b1;
    sol_y     = '0;
    busy      = 1'b0;
    cnt       = 0;
    model_y   = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        busy      = 1'b0;
        cnt       = 0;
        sol_valid = 1'b0;
        sol_ready = !hold_ready;
      end else if (sol_enable && mode != 1) begin
        busy      = 1'b1;
        cnt       = 4;
        sol_ready = 1'b0;
        model_y   = $signed(sol_a) * $signed(sol_x) * $signed(sol_x)
                  + $signed(sol_b) * $signed(sol_x) + $signed(sol_c);
      end else if (busy) begin
        if (cnt > 1) begin
          if (cnt == 2 && mode == 2) sol_valid = 1'b0;
          cnt--;
        end else if (cnt == 1) begin
          sol_valid = 1'b1;
          sol_y     = 16'(model_y);
          cnt       = 0;
        end else begin
          sol_valid = 1'b0;
          sol_ready = 1'b1;
          busy      = 1'b0;
        end
      end else begin
        sol_valid = (mode == 2);
        sol_ready = !hold_ready;
        if (mode == 2) sol_y = 16'h7777;
      end
    end
  end

  // Transaction log: one line per issue and per result.
  initial forever begin
    @(posedge clock);
    #1;
    if (reset && sol_enable) begin
      iss_x_q.push_back(int'($signed(sol_x)));
      $display("[TB] issue  x=%0d a=%0d b=%0d c=%0d", $signed(sol_x), $signed(sol_a),
               $signed(sol_b), $signed(sol_c));
    end
    if (reset && res_valid) begin
      res_y_q.push_back(int'($signed(res_y)));
      res_seq_q.push_back(int'(res_seq));
      $display("[TB] result y=%0d seq=%0d", $signed(res_y), res_seq);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b0;
    in_valid   = 1'b0;
    mode       = 0;
    hold_ready = 1'b0;
    repeat (2) @(negedge clock);
    iss_x_q.delete();
    res_y_q.delete();
    res_seq_q.delete();
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic push_tuple(input int x, input int a, input int b, input int c);
    int w = 0;
    in_x     = 8'(x);
    in_a     = 16'(a);
    in_b     = 16'(b);
    in_c     = 16'(c);
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_enable(input string tag);
    int w = 0;
    while (!sol_enable && w < 40) begin
      @(negedge clock);
      w++;
    end
    check_eq({tag, "_enable"}, sol_enable, 1);
  endtask

  // Called on the cycle sol_enable is seen; expects the result 5 cycles later.
  task automatic wait_result(input string tag, input int exp_y, input int exp_seq);
    int lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) check_eq({tag, "_en_pulse"}, sol_enable, 0);
    end while (!res_valid && lat < 40);
    check_eq({tag, "_latency"}, lat, 5);
    check_eq({tag, "_res_y"}, $signed(res_y), exp_y);
    check_eq({tag, "_res_seq"}, res_seq, exp_seq);
    @(negedge clock);
    check_eq({tag, "_res_pulse"}, res_valid, 0);
  endtask

  task automatic wait_results(input string tag, input int n);
    int w = 0;
    while (res_y_q.size() < n && w < 300) begin
      @(negedge clock);
      w++;
    end
    check_eq({tag, "_count"}, res_y_q.size(), n);
  endtask

  int acc;
  int k;
  int exp_y3   [5] = '{100, 121, 144, 169, 196};
  int exp_seq3 [5] = '{0, 1, 2, 3, 0};
  int exp_y4   [3] = '{4, 16384, -3};

  initial begin
    // reset state
    repeat (2) @(negedge clock);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_sol_enable", sol_enable, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_sol_x", sol_x, 0);
    check_eq("rst_res_y", res_y, 0);
    reset = 1'b1;
    @(negedge clock);

    // single tuple, minimum latency
    push_tuple(3, 2, -1, 5);
    check_eq("t1_en_early", sol_enable, 0);
    check_eq("t1_pending", pending, 1);
    @(negedge clock);
    check_eq("t1_enable", sol_enable, 1);
    check_eq("t1_sol_x", $signed(sol_x), 3);
    check_eq("t1_sol_a", $signed(sol_a), 2);
    check_eq("t1_sol_b", $signed(sol_b), -1);
    check_eq("t1_sol_c", $signed(sol_c), 5);
    wait_result("t1", 20, 0);

    // full FIFO with solver held busy, order preserved, tag wraps with SEQ_W=2
    do_reset();
    hold_ready = 1'b1;
    repeat (2) @(negedge clock);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_x = 8'(10 + i);
      in_a = 16'd1;
      in_b = 16'd0;
      in_c = 16'd0;
      in_valid = 1'b1;
      if (in_ready) acc++;
      @(negedge clock);
    end
    check_eq("t3_accepted", acc, 4);
    check_eq("t3_pending_full", pending, 4);
    check_eq("t3_in_ready_full", in_ready, 0);
    hold_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 30) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    check_eq("t3_pending_refill", pending, 4);
    wait_results("t3", 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t3_issue_x%0d", i), iss_x_q[i], 10 + i);
      check_eq($sformatf("t3_res_y%0d", i), res_y_q[i], exp_y3[i]);
      check_eq($sformatf("t3_res_seq%0d", i), res_seq_q[i], exp_seq3[i]);
    end

    // signed extremes
    do_reset();
    push_tuple(-2, 1, 0, 0);
    push_tuple(-128, 1, 0, 0);
    push_tuple(1, -1, -1, -1);
    wait_results("t4", 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t4_res_y%0d", i), res_y_q[i], exp_y4[i]);
      check_eq($sformatf("t4_res_seq%0d", i), res_seq_q[i], i);
    end

    // stale sol_valid held high across the issue
    do_reset();
    mode = 2;
    repeat (3) @(negedge clock);
    push_tuple(4, 0, 3, -2);
    wait_enable("t6");
    wait_result("t6", 10, 0);
    mode = 0;
    repeat (3) @(negedge clock);

    // timeout, then normal completion with the next tag
    do_reset();
    mode = 1;
    push_tuple(1, 1, 1, 1);
    wait_enable("t5");
    k = 0;
    while (!err && k < 40) begin
      @(negedge clock);
      k++;
    end
    check_eq("t5_err_cycle", k, 16);
    check_eq("t5_no_result", res_y_q.size(), 0);
    mode = 0;
    push_tuple(2, 1, 1, 1);
    wait_enable("t5b");
    wait_result("t5b", 7, 1);
    check_eq("t5_err_sticky", err, 1);

    // reset asserted mid WAIT_VALID with 3 queued (err still set from above)
    push_tuple(1, 1, 1, 1);
    push_tuple(1, 1, 1, 1);
    push_tuple(1, 1, 1, 1);
    push_tuple(1, 1, 1, 1);
    check_eq("t2_pending_before", pending, 3);
    reset = 1'b0;
    @(negedge clock);
    check_eq("t2_pending", pending, 0);
    check_eq("t2_sol_enable", sol_enable, 0);
    check_eq("t2_res_valid", res_valid, 0);
    check_eq("t2_err", err, 0);
    check_eq("t2_in_ready", in_ready, 1);
    iss_x_q.delete();
    res_y_q.delete();
    res_seq_q.delete();
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check_eq("t2_no_issue", iss_x_q.size(), 0);
    check_eq("t2_no_result", res_y_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
